// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU core ports, the arbiter and the memory pins.
// Signal suffixes are written from the arbiter's point of view (_i = into
// the arbiter, _o = out of the arbiter).
//
// Handshake: a requester raises *_req_i and holds its address/we/wdata
// stable until it sees *_gnt_o high in the same cycle; that cycle is the
// transfer. Exactly one cycle later *_rvalid_o pulses for one cycle with
// *_rdata_o (reads) or as a write acknowledge. Dropping a request before it
// is granted is legal and produces no response.
interface mem_port_arbiter_if;
  // instruction-fetch port
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  // data load/store port
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  // memory pins
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  // arbiter side
  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_addr_i, d_we_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_we_o, mem_data_o,
    input  mem_data_i
  );

  // core + memory side
  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_addr_i, d_we_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_we_o, mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between an instruction-fetch
// port and a data load/store port. One access per cycle; the response comes
// back one cycle after the grant, routed by a registered owner tag.
// ARB_MODE 0: round-robin. ARB_MODE 1: data priority, with fetch forced in
// after it has lost MAX_WAIT consecutive cycles.
module mem_port_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [3:0]          dbg_wait_cnt_o,
  output logic                dbg_last_gnt_o
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  // last_gnt: 0 = I was granted last, 1 = D was granted last
  logic       last_gnt_q, last_gnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // owner: bit 1 = D granted last cycle, bit 0 = I granted last cycle
  logic [1:0] owner_q, owner_d;
  logic       i_wins;
  logic       i_gnt;
  logic       d_gnt;

  // Grant decision: a lone requester always wins; contention resolved by mode.
  always_comb begin
    i_wins = 1'b0;
    if (ARB_MODE == 0) begin
      i_wins = last_gnt_q;
    end else begin
      i_wins = (wait_cnt_q == MaxWait);
    end
    i_gnt = ~reset & bus.i_req_i & (~bus.d_req_i | i_wins);
    d_gnt = ~reset & bus.d_req_i & (~bus.i_req_i | ~i_wins);
  end

  // Memory pin drive follows the winner; idle cycles drive all zeros.
  always_comb begin
    bus.mem_addr_o = 32'h0;
    bus.mem_we_o   = 1'b0;
    bus.mem_data_o = 32'h0;
    if (i_gnt) begin
      bus.mem_addr_o = bus.i_addr_i;
    end else if (d_gnt) begin
      bus.mem_addr_o = bus.d_addr_i;
      bus.mem_we_o   = bus.d_we_i;
      bus.mem_data_o = bus.d_wdata_i;
    end
  end

  // Next-state for owner tag, round-robin pointer and fetch starvation counter.
  always_comb begin
    owner_d    = {d_gnt, i_gnt};
    last_gnt_d = last_gnt_q;
    if (i_gnt || d_gnt) begin
      last_gnt_d = d_gnt;
    end
    wait_cnt_d = wait_cnt_q;
    if (!bus.i_req_i || i_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // State registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 2'b00;
      last_gnt_q <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else begin
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Response routing; masked while reset is high so a response whose grant
  // preceded reset never appears.
  always_comb begin
    bus.i_rvalid_o = owner_q[0] & ~reset;
    bus.d_rvalid_o = owner_q[1] & ~reset;
    bus.i_rdata_o  = bus.i_rvalid_o ? bus.mem_data_i : 32'h0;
    bus.d_rdata_o  = bus.d_rvalid_o ? bus.mem_data_i : 32'h0;
  end

  assign bus.i_gnt_o     = i_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign dbg_wait_cnt_o  = wait_cnt_q;
  assign dbg_last_gnt_o  = last_gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance driven from a vector
// table against a small memory model, and a data-priority instance driven by
// a hand-written contention sequence.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  logic [3:0] wc_a, wc_b;
  logic       lg_a, lg_b;

  mem_port_arbiter #(.ARB_MODE(0), .MAX_WAIT(4)) u_rr (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .dbg_wait_cnt_o(wc_a), .dbg_last_gnt_o(lg_a)
  );

  mem_port_arbiter #(.ARB_MODE(1), .MAX_WAIT(4)) u_dp (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .dbg_wait_cnt_o(wc_b), .dbg_last_gnt_o(lg_b)
  );

  // ---------------- memory model for the round-robin instance ----------------
  logic [31:0] mem_a [0:1023];
  logic [31:0] disp_a;
  logic [31:0] rd_a;
  logic        load_en;

  always @(posedge clk) begin
    if (load_en) begin
      mem_a[10'h010] <= 32'hDEADBEEF;
    end else if (bus_a.mem_we_o) begin
      if (bus_a.mem_addr_o[10]) disp_a <= bus_a.mem_data_o;
      else mem_a[bus_a.mem_addr_o[9:0]] <= bus_a.mem_data_o;
    end
    rd_a <= mem_a[bus_a.mem_addr_o[9:0]];
  end

  assign bus_a.mem_data_i = rd_a;
  assign bus_b.mem_data_i = 32'h0;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic        e_i_gnt;
    logic        e_d_gnt;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_i_rv;
    logic [31:0] e_i_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
    logic        chk_d_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic ir, input logic [31:0] ia,
    input logic dr, input logic [31:0] da, input logic dw, input logic [31:0] dd,
    input logic eig, input logic edg, input logic ewe, input logic [31:0] ea,
    input logic [31:0] ed, input logic eirv, input logic [31:0] eird,
    input logic edrv, input logic [31:0] edrd, input logic cdr);
    vec_t v;
    v.rst = rst; v.i_req = ir; v.i_addr = ia;
    v.d_req = dr; v.d_addr = da; v.d_we = dw; v.d_wdata = dd;
    v.e_i_gnt = eig; v.e_d_gnt = edg; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ed;
    v.e_i_rv = eirv; v.e_i_rd = eird; v.e_d_rv = edrv; v.e_d_rd = edrd;
    v.chk_d_rd = cdr;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_a(input vec_t v);
    rst_a           = v.rst;
    bus_a.i_req_i   = v.i_req;
    bus_a.i_addr_i  = v.i_addr;
    bus_a.d_req_i   = v.d_req;
    bus_a.d_addr_i  = v.d_addr;
    bus_a.d_we_i    = v.d_we;
    bus_a.d_wdata_i = v.d_wdata;
  endtask

  task automatic check_a(input int idx, input vec_t v);
    string p;
    p = $sformatf("rr[%0d]", idx);
    chk({p, ".i_gnt"},    32'(bus_a.i_gnt_o),    32'(v.e_i_gnt));
    chk({p, ".d_gnt"},    32'(bus_a.d_gnt_o),    32'(v.e_d_gnt));
    chk({p, ".mem_we"},   32'(bus_a.mem_we_o),   32'(v.e_we));
    chk({p, ".mem_addr"}, bus_a.mem_addr_o,      v.e_addr);
    chk({p, ".mem_data"}, bus_a.mem_data_o,      v.e_wdata);
    chk({p, ".i_rvalid"}, 32'(bus_a.i_rvalid_o), 32'(v.e_i_rv));
    chk({p, ".i_rdata"},  bus_a.i_rdata_o,       v.e_i_rd);
    chk({p, ".d_rvalid"}, 32'(bus_a.d_rvalid_o), 32'(v.e_d_rv));
    if (v.chk_d_rd) chk({p, ".d_rdata"}, bus_a.d_rdata_o, v.e_d_rd);
  endtask

  task automatic drive_b(input logic rst, input logic ir, input logic dr);
    rst_b           = rst;
    bus_b.i_req_i   = ir;
    bus_b.i_addr_i  = 32'h10;
    bus_b.d_req_i   = dr;
    bus_b.d_addr_i  = 32'h5;
    bus_b.d_we_i    = 1'b0;
    bus_b.d_wdata_i = 32'h0;
  endtask

  // ---------------- test ----------------
  initial begin
    load_en = 1'b1;
    drive_a(mk(1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    drive_b(1'b1, 1'b0, 1'b0);

    //                rst ir ia     dr da      dw dd            eig edg ewe ea       ed            eirv eird          edrv edrd          cdr
    vecs.push_back(mk(1, 1,'h10,   1,'h5,    0, 0,            0,  0,  0,  0,       0,            0,   0,            0,   0,            1)); // 0 reset, both req
    vecs.push_back(mk(1, 1,'h10,   1,'h5,    0, 0,            0,  0,  0,  0,       0,            0,   0,            0,   0,            1)); // 1 reset, both req
    vecs.push_back(mk(0, 1,'h10,   1,'h10,   0, 0,            0,  1,  0,  'h10,    0,            0,   0,            0,   0,            1)); // 2 first contention -> D
    vecs.push_back(mk(0, 1,'h10,   0,0,      0, 0,            1,  0,  0,  'h10,    0,            0,   0,            1,   'hDEADBEEF,   1)); // 3 I only
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            1,   'hDEADBEEF,   0,   0,            1)); // 4 I response
    vecs.push_back(mk(0, 0,0,      1,'h5,    1, 'h12345678,   0,  1,  1,  'h5,     'h12345678,   0,   0,            0,   0,            1)); // 5 D write
    vecs.push_back(mk(0, 0,0,      1,'h5,    0, 0,            0,  1,  0,  'h5,     0,            0,   0,            1,   0,            0)); // 6 D read, write ack
    vecs.push_back(mk(0, 0,0,      1,'h400,  1, 'hA5,         0,  1,  1,  'h400,   'hA5,         0,   0,            1,   'h12345678,   1)); // 7 display write, RAW data
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            0,   0,            1,   0,            0)); // 8 display ack
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            0,   0,            0,   0,            1)); // 9 idle
    vecs.push_back(mk(0, 1,'h10,   0,0,      0, 0,            1,  0,  0,  'h10,    0,            0,   0,            0,   0,            1)); // 10 I only
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            0,  1,  0,  'h5,     0,            1,   'hDEADBEEF,   0,   0,            1)); // 11 RR D
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            1,  0,  0,  'h10,    0,            0,   0,            1,   'h12345678,   1)); // 12 RR I
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            0,  1,  0,  'h5,     0,            1,   'hDEADBEEF,   0,   0,            1)); // 13 RR D
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            1,  0,  0,  'h10,    0,            0,   0,            1,   'h12345678,   1)); // 14 RR I
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            0,  1,  0,  'h5,     0,            1,   'hDEADBEEF,   0,   0,            1)); // 15 RR D
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            1,  0,  0,  'h10,    0,            0,   0,            1,   'h12345678,   1)); // 16 RR I
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            1,   'hDEADBEEF,   0,   0,            1)); // 17 last I response
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            0,   0,            0,   0,            1)); // 18 idle
    vecs.push_back(mk(0, 1,'h10,   0,0,      0, 0,            1,  0,  0,  'h10,    0,            0,   0,            0,   0,            1)); // 19 I grant at N
    vecs.push_back(mk(1, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            0,   0,            0,   0,            1)); // 20 reset at N+1
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            0,   0,            0,   0,            1)); // 21 no late response
    vecs.push_back(mk(0, 1,'h10,   1,'h5,    0, 0,            0,  1,  0,  'h5,     0,            0,   0,            0,   0,            1)); // 22 post-reset contention -> D
    vecs.push_back(mk(0, 0,0,      0,0,      0, 0,            0,  0,  0,  0,       0,            0,   0,            1,   'h12345678,   1)); // 23 D response

    @(posedge clk);
    #1 load_en = 1'b0;

    foreach (vecs[k]) begin
      @(posedge clk);
      #1 drive_a(vecs[k]);
      @(negedge clk);
      n_vec++;
      check_a(k, vecs[k]);
    end
    chk("display_reg", disp_a, 32'hA5);
    n_vec++;

    // ---- data-priority instance: reset with both requests high ----
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 drive_b(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      n_vec++;
      chk("dp_rst.i_gnt",    32'(bus_b.i_gnt_o),    32'h0);
      chk("dp_rst.d_gnt",    32'(bus_b.d_gnt_o),    32'h0);
      chk("dp_rst.mem_we",   32'(bus_b.mem_we_o),   32'h0);
      chk("dp_rst.i_rvalid", 32'(bus_b.i_rvalid_o), 32'h0);
      chk("dp_rst.d_rvalid", 32'(bus_b.d_rvalid_o), 32'h0);
    end

    // ---- both held high: D,D,D,D,I repeating ----
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back((k % 5 == 4) ? 2'b01 : 2'b10);
      @(posedge clk);
      #1 drive_b(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      n_vec++;
      chk($sformatf("dp[%0d].gnt", k), 32'({bus_b.d_gnt_o, bus_b.i_gnt_o}), 32'(exp_q.pop_front()));
      chk($sformatf("dp[%0d].wait_cnt", k), 32'(wc_b), k % 5);
      chk($sformatf("dp[%0d].mem_addr", k), bus_b.mem_addr_o, (k % 5 == 4) ? 32'h10 : 32'h5);
      if (k > 0) begin
        chk($sformatf("dp[%0d].i_rvalid", k), 32'(bus_b.i_rvalid_o), (k % 5 == 0) ? 32'h1 : 32'h0);
        chk($sformatf("dp[%0d].d_rvalid", k), 32'(bus_b.d_rvalid_o), (k % 5 == 0) ? 32'h0 : 32'h1);
      end
    end

    // ---- request dropped before grant: no response ----
    @(posedge clk);
    #1 drive_b(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive_b(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    chk("dp_idle.i_rvalid", 32'(bus_b.i_rvalid_o), 32'h0);
    chk("dp_idle.d_rvalid", 32'(bus_b.d_rvalid_o), 32'h0);
    chk("dp_idle.wait_cnt", 32'(wc_b), 32'h0);

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port, 1024-word synchronous program/data memory (with its memory-mapped display register) between an instruction-fetch requester and a data load/store requester. It issues at most one memory access per cycle and returns each response one cycle after grant. Arbitration is either round-robin or data-priority with a starvation guard for fetch. It sits between the CPU core ports and the memory's addr/we/data_in/data_out pins.

Parameters:
ARB_MODE, 0, 0 = round-robin between I and D; 1 = D-priority with fetch starvation guard
MAX_WAIT, 4, ARB_MODE=1 only: consecutive cycles the I port may lose before it is forced a grant (range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
i_req_i  in  1  fetch request; held with i_addr_i stable until i_gnt_o
i_addr_i  in  32  fetch word address
i_gnt_o  out  1  fetch accepted this cycle (combinational)
i_rvalid_o  out  1  fetch response valid (registered)
i_rdata_o  out  32  fetch data, valid when i_rvalid_o
d_req_i  in  1  data request; held with addr/we/wdata stable until d_gnt_o
d_addr_i  in  32  data word address
d_we_i  in  1  1 = write, 0 = read
d_wdata_i  in  32  write data
d_gnt_o  out  1  data request accepted this cycle (combinational)
d_rvalid_o  out  1  data response/ack valid (registered)
d_rdata_o  out  32  read data, valid when d_rvalid_o and the access was a read
mem_addr_o  out  32  to memory addr_i
mem_we_o  out  1  to memory we_i
mem_data_o  out  32  to memory data_in_i
mem_data_i  in  32  from memory data_out_o (1-cycle registered read)

Behaviour:
- Grant decision is combinational from req inputs and registered state; at most one of i_gnt_o/d_gnt_o is high per cycle. No grant is given without a req.
- Single requester active: it is granted the same cycle.
- Both active, ARB_MODE=0: grant goes to the port not granted last. last_gnt register (reset = I granted last, so D wins first contention). last_gnt updates only on a grant.
- Both active, ARB_MODE=1: D wins unless wait_cnt == MAX_WAIT, in which case I wins. wait_cnt (4-bit) increments each cycle i_req_i is high and I is not granted. It clears on an I grant or when i_req_i is low, and saturates at MAX_WAIT.
- Memory drive: on an I grant, mem_addr_o=i_addr_i, mem_we_o=0, mem_data_o=0. On a D grant, mem_addr_o=d_addr_i, mem_we_o=d_we_i, mem_data_o=d_wdata_i. With no grant, all three are 0. Address decode (bit 10 = display) stays in memory; addresses pass through unmodified.
- Response: a 2-bit owner register captures {D granted, I granted} each cycle. The cycle after a grant, the matching rvalid is 1 for exactly one cycle, and rdata = mem_data_i is routed to that port. Writes also produce d_rvalid_o as an ack; d_rdata_o is don't-care for writes. Back-to-back grants give back-to-back rvalids, throughput 1 access/cycle.
- rdata outputs are 0 when the corresponding rvalid is 0.
- Reset (any cycle, including with a response pending): gnts forced 0, mem_we_o=0, mem_addr_o=0, mem_data_o=0 while reset is high. Owner register, i_rvalid_o and d_rvalid_o clear to 0. The pending response is dropped. wait_cnt=0, last_gnt=I.
- Request dropped before grant: it is legal and ignored, with no response. A req change while granted in the same cycle is undefined; requesters must not do it.
- Read-after-write to the same address from D on consecutive grants returns the new data.

Test Plan:
- Reset: hold reset 2 cycles with both reqs high -> gnts 0, mem_we_o 0, rvalids 0. First post-reset contention cycle, both modes -> d_gnt_o=1.
- I only, addr 0x10, memory preloaded 0xDEADBEEF -> i_gnt_o same cycle, i_rvalid_o=1 next cycle with i_rdata_o=0xDEADBEEF, d_rvalid_o=0.
- D write 0x5 <- 0x12345678, then D read 0x5 next cycle -> d_rvalid_o two consecutive cycles, second with d_rdata_o=0x12345678. D write addr 0x400 data 0xA5 -> mem_we_o=1, mem_addr_o=0x400, memory display_o=0xA5.
- ARB_MODE=0, both reqs held high 6 cycles -> grants alternate D,I,D,I,D,I; rvalids alternate one cycle later.
- ARB_MODE=1, MAX_WAIT=4, both held high -> D granted 4 cycles, I granted cycle 5, wait_cnt back to 0, pattern repeats every 5 cycles.
- Grant to I at cycle N, reset asserted at N+1 -> i_rvalid_o stays 0 at N+1 and after; no spurious response after reset release.
